// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame width and baud divisor helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    function automatic int bps_cnt(input int clk_freq, input int uart_freq);
        return clk_freq / uart_freq;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial pin in, byte plus status strobes out.
interface uart_rx_if
    import uart_pkg::*;
();
    logic                      uart_rxd;
    logic [UART_DATA_BITS-1:0] uart_data;
    logic                      uart_rx_done;
    logic                      uart_rx_busy;
    logic                      uart_frame_err;

    modport master (
        input  uart_rxd,
        output uart_data,
        output uart_rx_done,
        output uart_rx_busy,
        output uart_frame_err
    );

    modport slave (
        output uart_rxd,
        input  uart_data,
        input  uart_rx_done,
        input  uart_rx_busy,
        input  uart_frame_err
    );
endinterface

// File: rtl/uart_rx_sync.sv
// 2-FF synchroniser plus delay flop and falling-edge detect for an async pin.
// Flops reset high so an idle-high line never fakes an edge at reset release.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_fall = r_s3 & ~r_s2;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit 3-sample majority vote, one-cycle done/error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int UART_FREQ = 9600
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.master bus
);
    localparam int BPS_CNT  = bps_cnt(CLK_FREQ, UART_FREQ);
    localparam int HALF_CNT = BPS_CNT / 2;

    localparam logic [15:0] BPS_M1  = 16'(BPS_CNT - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF_CNT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic w_rxd;
    logic w_fall;
    logic w_maj;

    uart_state_e               r_state, w_state_nxt;
    logic [15:0]               r_clk_cnt, w_cnt_nxt;
    logic [2:0]                r_bit_cnt, w_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [UART_DATA_BITS-1:0] r_data, w_data_nxt;
    logic                      r_done, w_done_nxt;
    logic                      r_err, w_err_nxt;
    logic [1:0]                r_hist;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(bus.uart_rxd),
        .o_sync (w_rxd),
        .o_fall (w_fall)
    );

    // Vote over the two previous synchronised samples and the current one.
    assign w_maj = (r_hist[1] & r_hist[0]) |
                   (r_hist[1] & w_rxd) |
                   (r_hist[0] & w_rxd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_hist    <= 2'b11;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_cnt_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_hist    <= {r_hist[0], w_rxd};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_clk_cnt + 16'd1;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall)
                    w_state_nxt = START;
            end
            START: begin
                if (r_clk_cnt == HALF_M1) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
                    w_state_nxt = w_maj ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_clk_cnt == BPS_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_maj, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == LAST_BIT)
                        w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (r_clk_cnt == BPS_M1) begin
                    w_cnt_nxt = '0;
                    if (w_maj) begin
                        w_data_nxt  = r_shift;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold here until the line is released so a stuck-low pin reports once.
                w_cnt_nxt = '0;
                if (w_rxd)
                    w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.uart_data      = r_data;
    assign bus.uart_rx_done   = r_done;
    assign bus.uart_frame_err = r_err;
    assign bus.uart_rx_busy   = (r_state != IDLE);
endmodule
